// File: rtl/axi_spi_pkg.sv
// Shared constants for the AXI4-Lite register bank in front of the SPI master:
// register word offsets, CTRL field positions, AXI response codes and the STATUS word layout.
package axi_spi_pkg;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_TIMING = 3'd1;
  localparam logic [2:0] OFF_TXDATA = 3'd2;
  localparam logic [2:0] OFF_RXDATA = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  localparam int CFG_W       = 6;
  localparam int TIMING_W    = 24;
  localparam int CTRL_GO_BIT = 8;
  localparam int STATUS_OVR  = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] status_word(input logic busy, input logic rx_valid,
                                              input logic start, input logic overrun);
    return {28'd0, overrun, start, rx_valid, busy};
  endfunction

endpackage

// File: rtl/axi_lite_wr_ctrl.sv
// AXI4-Lite write channel: latches AW and W independently, fires a single wr_en
// once both are held, and returns the response until the master takes it.
module axi_lite_wr_ctrl
  import axi_spi_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  input  logic              wr_err
);

  logic              aw_held_r;
  logic              w_held_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       data_r;
  logic [3:0]        strb_r;
  logic              bvalid_r;
  logic [1:0]        bresp_r;

  assign awready = ~aw_held_r & ~bvalid_r;
  assign wready  = ~w_held_r & ~bvalid_r;
  assign wr_en   = aw_held_r & w_held_r & ~bvalid_r;
  assign wr_addr = addr_r;
  assign wr_data = data_r;
  assign wr_strb = strb_r;
  assign bvalid  = bvalid_r;
  assign bresp   = bresp_r;

  // Channel holds and response; the holds stay set until B is taken so nothing new is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      addr_r    <= '0;
      data_r    <= 32'd0;
      strb_r    <= 4'd0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else if (bvalid_r && bready) begin
      bvalid_r  <= 1'b0;
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
    end else begin
      if (wr_en) begin
        bvalid_r <= 1'b1;
        bresp_r  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end
      if (awvalid && awready) begin
        aw_held_r <= 1'b1;
        addr_r    <= awaddr;
      end
      if (wvalid && wready) begin
        w_held_r <= 1'b1;
        data_r   <= wdata;
        strb_r   <= wstrb;
      end
    end
  end

endmodule

// File: rtl/axi_spi_regs.sv
// AXI4-Lite register bank driving the SPI master: config/timing/TX registers,
// the GO/busy start handshake, RX capture on busy fall, and the registered read path.
module axi_spi_regs
  import axi_spi_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              GCLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              start_o,
  input  logic              busy_i,
  output logic [5:0]        spi_cfg_o,
  output logic [23:0]       spi_timing_o,
  output logic [31:0]       mosi_data_o,
  input  logic [31:0]       miso_data_i
);

  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [31:0]       wr_data_s;
  logic [3:0]        wr_strb_s;
  logic              wr_err_s;

  logic [CFG_W-1:0]    cfg_r;
  logic [TIMING_W-1:0] timing_r;
  logic [31:0]         tx_r;
  logic [31:0]         rx_r;
  logic                rx_valid_r;
  logic                overrun_r;
  logic                start_r;
  logic                busy_q_r;
  logic [31:0]         rdata_r;
  logic [1:0]          rresp_r;
  logic                rvalid_r;

  logic [2:0]  wr_off_s;
  logic [2:0]  rd_off_s;
  logic        lock_s;
  logic        wr_ok_s;
  logic        go_s;
  logic        complete_s;
  logic        ar_hs_s;
  logic        rx_rd_s;
  logic        ovr_clr_s;
  logic [31:0] rd_data_s;
  logic [1:0]  rd_resp_s;
  logic        unused_s;

  axi_lite_wr_ctrl #(.ADDR_W(ADDR_W)) u_wr_ctrl (
    .clk     (GCLK),
    .rst_n   (RST),
    .awaddr  (s_axi_awaddr),
    .awvalid (s_axi_awvalid),
    .awready (s_axi_awready),
    .wdata   (s_axi_wdata),
    .wstrb   (s_axi_wstrb),
    .wvalid  (s_axi_wvalid),
    .wready  (s_axi_wready),
    .bresp   (s_axi_bresp),
    .bvalid  (s_axi_bvalid),
    .bready  (s_axi_bready),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (wr_data_s),
    .wr_strb (wr_strb_s),
    .wr_err  (wr_err_s)
  );

  // Only addr[4:2] selects a register; the remaining address bits are don't-care.
  assign unused_s   = ^{wr_addr_s, s_axi_araddr};
  assign wr_off_s   = wr_addr_s[4:2];
  assign rd_off_s   = s_axi_araddr[4:2];
  assign lock_s     = start_r | busy_i;
  assign wr_ok_s    = wr_en_s & ~wr_err_s;
  assign go_s       = wr_ok_s & (wr_off_s == OFF_CTRL) & wr_strb_s[1] & wr_data_s[CTRL_GO_BIT];
  assign ovr_clr_s  = wr_ok_s & (wr_off_s == OFF_STATUS) & wr_data_s[STATUS_OVR];
  assign complete_s = busy_q_r & ~busy_i;
  assign ar_hs_s    = s_axi_arvalid & ~rvalid_r;
  assign rx_rd_s    = ar_hs_s & (rd_off_s == OFF_RXDATA);

  assign s_axi_arready = ~rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = rresp_r;
  assign s_axi_rvalid  = rvalid_r;
  assign start_o       = start_r;
  assign spi_cfg_o     = cfg_r;
  assign spi_timing_o  = timing_r;
  assign mosi_data_o   = tx_r;

  // Write decode: SPI-side registers are frozen while a transfer is pending or running.
  always_comb begin
    wr_err_s = 1'b1;
    case (wr_off_s)
      OFF_CTRL, OFF_TIMING, OFF_TXDATA: wr_err_s = lock_s;
      OFF_STATUS:                       wr_err_s = 1'b0;
      default:                          wr_err_s = 1'b1;
    endcase
  end

  // SPI configuration, timing and TX word with per-byte strobes.
  always_ff @(posedge GCLK or negedge RST) begin
    if (!RST) begin
      cfg_r    <= '0;
      timing_r <= '0;
      tx_r     <= 32'd0;
    end else if (wr_ok_s) begin
      case (wr_off_s)
        OFF_CTRL: begin
          if (wr_strb_s[0]) cfg_r <= wr_data_s[CFG_W-1:0];
        end
        OFF_TIMING: begin
          for (int b = 0; b < 3; b++)
            if (wr_strb_s[b]) timing_r[8*b +: 8] <= wr_data_s[8*b +: 8];
        end
        OFF_TXDATA: begin
          for (int b = 0; b < 4; b++)
            if (wr_strb_s[b]) tx_r[8*b +: 8] <= wr_data_s[8*b +: 8];
        end
        default: ;
      endcase
    end
  end

  // Start request: raised by GO, dropped once the master reports busy.
  always_ff @(posedge GCLK or negedge RST) begin
    if (!RST) begin
      start_r <= 1'b0;
    end else if (go_s) begin
      start_r <= 1'b1;
    end else if (start_r && busy_i) begin
      start_r <= 1'b0;
    end
  end

  // RX capture on busy fall; a capture beats a same-cycle RXDATA read or overrun clear.
  always_ff @(posedge GCLK or negedge RST) begin
    if (!RST) begin
      busy_q_r   <= 1'b0;
      rx_r       <= 32'd0;
      rx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      busy_q_r <= busy_i;
      if (complete_s) begin
        rx_r       <= miso_data_i;
        rx_valid_r <= 1'b1;
      end else if (rx_rd_s) begin
        rx_valid_r <= 1'b0;
      end
      if (complete_s && rx_valid_r) begin
        overrun_r <= 1'b1;
      end else if (ovr_clr_s) begin
        overrun_r <= 1'b0;
      end
    end
  end

  // Read mux; GO always reads back as 0.
  always_comb begin
    rd_data_s = 32'd0;
    rd_resp_s = RESP_OKAY;
    case (rd_off_s)
      OFF_CTRL:   rd_data_s = {26'd0, cfg_r};
      OFF_TIMING: rd_data_s = {8'd0, timing_r};
      OFF_TXDATA: rd_data_s = tx_r;
      OFF_RXDATA: rd_data_s = rx_r;
      OFF_STATUS: rd_data_s = status_word(busy_i, rx_valid_r, start_r, overrun_r);
      default: begin
        rd_data_s = 32'd0;
        rd_resp_s = RESP_SLVERR;
      end
    endcase
  end

  // Registered read response, held until the master accepts it.
  always_ff @(posedge GCLK or negedge RST) begin
    if (!RST) begin
      rdata_r  <= 32'd0;
      rresp_r  <= RESP_OKAY;
      rvalid_r <= 1'b0;
    end else if (ar_hs_s) begin
      rdata_r  <= rd_data_s;
      rresp_r  <= rd_resp_s;
      rvalid_r <= 1'b1;
    end else if (rvalid_r && s_axi_rready) begin
      rvalid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_spi_regs.sv
// Scoreboard bench for axi_spi_regs: tasks push expected B/R responses from a
// register-map model, a negedge monitor pops and compares on each handshake.
module tb_axi_spi_regs;

  logic        GCLK = 1'b0;
  logic        RST;
  logic [4:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [4:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        start_o;
  logic        busy_i;
  logic [5:0]  spi_cfg_o;
  logic [23:0] spi_timing_o;
  logic [31:0] mosi_data_o;
  logic [31:0] miso_data_i;

  always #5 GCLK = ~GCLK;

  axi_spi_regs #(.ADDR_W(5)) dut (
    .GCLK(GCLK), .RST(RST),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .start_o(start_o),
    .busy_i(busy_i), .spi_cfg_o(spi_cfg_o), .spi_timing_o(spi_timing_o),
    .mosi_data_o(mosi_data_o), .miso_data_i(miso_data_i)
  );

  int checks = 0;
  int errors = 0;
  int b_cnt  = 0;
  int r_cnt  = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];

  // reference model of the register map
  logic [5:0]  m_cfg;
  logic [23:0] m_timing;
  logic [31:0] m_tx, m_rx;
  logic        m_rxv, m_ovr, m_start, m_busy;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cfg = 6'd0; m_timing = 24'd0; m_tx = 32'd0; m_rx = 32'd0;
    m_rxv = 1'b0; m_ovr = 1'b0; m_start = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
    logic [31:0] mask;
    int          off;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    off  = int'(a) / 4;
    resp = 2'b10;
    if (off == 4) begin
      if (d[3]) m_ovr = 1'b0;
      resp = 2'b00;
    end else if (off <= 2 && !(m_start || m_busy)) begin
      resp = 2'b00;
      if (off == 0) begin
        m_cfg = (m_cfg & ~mask[5:0]) | (d[5:0] & mask[5:0]);
        if (s[1] && d[8]) m_start = 1'b1;
      end else if (off == 1) begin
        m_timing = (m_timing & ~mask[23:0]) | (d[23:0] & mask[23:0]);
      end else begin
        m_tx = (m_tx & ~mask) | (d & mask);
      end
    end
  endtask

  task automatic model_read(input logic [4:0] a, output logic [33:0] exp);
    int off;
    off = int'(a) / 4;
    case (off)
      0: exp = {2'b00, 26'd0, m_cfg};
      1: exp = {2'b00, 8'd0, m_timing};
      2: exp = {2'b00, m_tx};
      3: begin exp = {2'b00, m_rx}; m_rxv = 1'b0; end
      4: exp = {2'b00, 28'd0, m_ovr, m_start, m_rxv, m_busy};
      default: exp = {2'b10, 32'd0};
    endcase
  endtask

  // monitor: compare every B and R handshake against the scoreboard queues
  always @(negedge GCLK) begin
    if (RST === 1'b1) begin
      if (s_axi_bvalid && s_axi_bready) begin
        b_cnt++;
        if (bq.size() == 0) chk("bresp_unexpected", 34'd1, 34'd0);
        else chk("bresp", {32'd0, s_axi_bresp}, {32'd0, bq.pop_front()});
      end
      if (s_axi_rvalid && s_axi_rready) begin
        r_cnt++;
        if (rq.size() == 0) chk("rresp_unexpected", 34'd1, 34'd0);
        else chk("rdata_rresp", {s_axi_rresp, s_axi_rdata}, rq.pop_front());
      end
    end
  end

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] e;
    int b0;
    bit aw_done, w_done, aw_hit, w_hit;
    model_write(a, d, s, e);
    bq.push_back(e);
    b0 = b_cnt;
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      aw_hit = s_axi_awvalid && s_axi_awready;
      w_hit  = s_axi_wvalid && s_axi_wready;
      @(negedge GCLK);
      if (aw_hit) begin s_axi_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hit)  begin s_axi_wvalid = 1'b0;  w_done = 1'b1;  end
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    if (!(aw_done && w_done)) chk("aw_w_accept_timeout", 34'd0, 34'd1);
    for (int i = 0; i < 20 && b_cnt == b0; i++) @(negedge GCLK);
    if (b_cnt == b0) chk("bvalid_timeout", 34'd0, 34'd1);
    @(negedge GCLK);
  endtask

  task automatic axi_read(input logic [4:0] a);
    logic [33:0] e;
    int r0;
    bit done, hit;
    model_read(a, e);
    rq.push_back(e);
    r0 = r_cnt;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      hit = s_axi_arvalid && s_axi_arready;
      @(negedge GCLK);
      if (hit) begin s_axi_arvalid = 1'b0; done = 1'b1; end
    end
    s_axi_arvalid = 1'b0;
    if (!done) chk("ar_accept_timeout", 34'd0, 34'd1);
    for (int i = 0; i < 20 && r_cnt == r0; i++) @(negedge GCLK);
    if (r_cnt == r0) chk("rvalid_timeout", 34'd0, 34'd1);
    @(negedge GCLK);
  endtask

  task automatic set_busy(input logic v);
    busy_i = v;
    if (v && !m_busy) m_start = 1'b0;
    if (!v && m_busy) begin
      m_ovr = m_ovr | m_rxv;
      m_rxv = 1'b1;
      m_rx  = miso_data_i;
    end
    m_busy = v;
    @(negedge GCLK);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_start_o"}, {33'd0, start_o}, {33'd0, m_start});
    chk({tag, "_spi_cfg_o"}, {28'd0, spi_cfg_o}, {28'd0, m_cfg});
    chk({tag, "_spi_timing_o"}, {10'd0, spi_timing_o}, {10'd0, m_timing});
    chk({tag, "_mosi_data_o"}, {2'd0, mosi_data_o}, {2'd0, m_tx});
  endtask

  initial begin
    logic [1:0] e;
    int         b0;
    RST = 1'b0;
    s_axi_awaddr = 5'd0; s_axi_awvalid = 1'b0; s_axi_wdata = 32'd0; s_axi_wstrb = 4'd0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b1; s_axi_araddr = 5'd0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1; busy_i = 1'b0; miso_data_i = 32'd0;
    model_reset();
    repeat (3) @(negedge GCLK);
    RST = 1'b1;
    @(negedge GCLK);
    check_outs("reset");
    chk("reset_bvalid", {33'd0, s_axi_bvalid}, 34'd0);
    chk("reset_rvalid", {33'd0, s_axi_rvalid}, 34'd0);
    chk("reset_rdata", {s_axi_rresp, s_axi_rdata}, 34'd0);

    // reset in the middle of a CTRL+GO write
    s_axi_bready = 1'b0;
    s_axi_awaddr = 5'h00; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0000_0112; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(negedge GCLK);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(negedge GCLK);
    chk("prereset_cfg", {28'd0, spi_cfg_o}, 34'h12);
    RST = 1'b0;
    #1;
    chk("midreset_bvalid", {33'd0, s_axi_bvalid}, 34'd0);
    chk("midreset_start", {33'd0, start_o}, 34'd0);
    chk("midreset_cfg", {28'd0, spi_cfg_o}, 34'd0);
    @(negedge GCLK);
    s_axi_bready = 1'b1;
    RST = 1'b1;
    model_reset();
    @(negedge GCLK);
    axi_write(5'h04, 32'h0011_2233, 4'hF);
    check_outs("post_reset_write");

    // GO and the start handshake
    axi_write(5'h00, 32'h0000_0112, 4'hF);
    check_outs("go");
    repeat (5) begin
      @(negedge GCLK);
      chk("start_held", {33'd0, start_o}, 34'd1);
    end
    set_busy(1'b1);
    check_outs("busy_rise");

    // lock while busy, completion, unlock
    axi_write(5'h08, 32'hDEAD_BEEF, 4'hF);
    check_outs("locked_tx");
    miso_data_i = 32'hA5A5_0F0F;
    set_busy(1'b0);
    axi_write(5'h08, 32'hDEAD_BEEF, 4'hF);
    check_outs("unlocked_tx");
    axi_read(5'h10);
    axi_read(5'h0C);
    axi_read(5'h10);

    // overrun and its W1C clear
    miso_data_i = 32'h1111_2222; set_busy(1'b1); set_busy(1'b0);
    miso_data_i = 32'h3333_4444; set_busy(1'b1); set_busy(1'b0);
    axi_read(5'h10);
    axi_write(5'h10, 32'h0000_0008, 4'hF);
    axi_read(5'h10);

    // W ahead of AW, B stalled
    model_write(5'h08, 32'h1234_5678, 4'hF, e);
    bq.push_back(e);
    b0 = b_cnt;
    s_axi_bready = 1'b0;
    s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(negedge GCLK);
    repeat (2) begin
      chk("wready_after_accept", {33'd0, s_axi_wready}, 34'd0);
      @(negedge GCLK);
    end
    s_axi_wvalid = 1'b0;
    s_axi_awaddr = 5'h08; s_axi_awvalid = 1'b1;
    @(negedge GCLK);
    s_axi_awvalid = 1'b0;
    @(negedge GCLK);
    repeat (4) begin
      chk("bvalid_stalled", {33'd0, s_axi_bvalid}, 34'd1);
      chk("awready_stalled", {33'd0, s_axi_awready}, 34'd0);
      @(negedge GCLK);
    end
    s_axi_bready = 1'b1;
    repeat (4) @(negedge GCLK);
    chk("single_b_handshake", 34'(b_cnt - b0), 34'd1);
    check_outs("stall_write");
    axi_read(5'h14);

    // randomized traffic
    for (int it = 0; it < 250; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 3) begin
        axi_write({3'($urandom_range(0, 7)), 2'($urandom)}, $urandom, 4'($urandom));
      end else if (op <= 6) begin
        axi_read({3'($urandom_range(0, 7)), 2'($urandom)});
      end else begin
        miso_data_i = $urandom;
        set_busy(~busy_i);
      end
      check_outs("random");
    end

    repeat (4) @(negedge GCLK);
    chk("bq_drained", 34'(bq.size()), 34'd0);
    chk("rq_drained", 34'(rq.size()), 34'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
